// File: rtl/fx_regbank.sv
// rtl/fx_regbank.sv - fx-bus register bank: config registers, coherent status reads, sticky events, irq
// Optional feature macro: FX_REGBANK_LOCK_EN (config write lock at local address 0x000F)

module fx_regbank #(
  parameter int             NCH      = 2,
  parameter int             NCFG     = 8,
  parameter logic [15:0]    STU_BASE = 16'h0010,
  parameter logic [15:0]    CFG_BASE = 16'h0080,
  parameter logic [255:0]   CFG_RST  = 256'h9F9E9D9C9B9A99989796959493929190_8F8E8D8C8B8A89888786858483828101
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [5:0]          dev_id,
  input  logic                fx_wr,
  input  logic [21:0]         fx_waddr,
  input  logic [7:0]          fx_data,
  input  logic                fx_rd,
  input  logic [21:0]         fx_raddr,
  output logic [7:0]          fx_q,
  output logic                fx_qv,
  output logic [NCFG*8-1:0]   cfg_out,
  output logic [NCFG-1:0]     cfg_wstb,
  input  logic [NCH*16-1:0]   stu_data,
  input  logic [NCH-1:0]      stu_evt,
  output logic                irq
);

  localparam logic [15:0] A_ID   = 16'h0000;
  localparam logic [15:0] A_NCH  = 16'h0001;
  localparam logic [15:0] A_NCFG = 16'h0002;
  localparam logic [15:0] A_EVT  = 16'h0008;
  localparam logic [15:0] A_MASK = 16'h0009;

  logic              rd_acc;
  logic              wr_acc;
  logic [15:0]       r_loc;
  logic [15:0]       w_loc;
  logic [7:0]        rd_data;
  logic [NCH-1:0]    snap_hit;
  logic [NCH-1:0]    evt_clr;
  logic [NCH-1:0]    evt_q;
  logic [NCH-1:0]    mask_q;
  logic [NCH*16-1:0] shadow_q;
  logic [NCFG*8-1:0] cfg_q;
  logic [NCFG-1:0]   cfg_we;
  logic              cfg_unlocked;

  assign rd_acc  = fx_rd && (fx_raddr[21:16] == dev_id);
  assign wr_acc  = fx_wr && (fx_waddr[21:16] == dev_id);
  assign r_loc   = fx_raddr[15:0];
  assign w_loc   = fx_waddr[15:0];
  assign cfg_out = cfg_q;

`ifdef FX_REGBANK_LOCK_EN
  localparam logic [15:0] A_LOCK = 16'h000F;
  logic locked_q;

  // Lock register: only the key value 0xA5 opens config writes, anything else closes them
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      locked_q <= 1'b1;
    end else if (wr_acc && (w_loc == A_LOCK)) begin
      locked_q <= (fx_data != 8'hA5);
    end
  end

  assign cfg_unlocked = ~locked_q;
`else
  assign cfg_unlocked = 1'b1;
`endif

  // Read mux over current register state, so a same-cycle write is not visible to the read
  always_comb begin
    rd_data  = 8'h55;
    snap_hit = '0;
    if (r_loc == A_ID)   rd_data = {2'b00, dev_id};
    if (r_loc == A_NCH)  rd_data = 8'(NCH);
    if (r_loc == A_NCFG) rd_data = 8'(NCFG);
    if (r_loc == A_EVT) begin
      rd_data = '0;
      rd_data[NCH-1:0] = evt_q;
    end
    if (r_loc == A_MASK) begin
      rd_data = '0;
      rd_data[NCH-1:0] = mask_q;
    end
`ifdef FX_REGBANK_LOCK_EN
    if (r_loc == A_LOCK) rd_data = {7'b0, ~locked_q};
`endif
    for (int i = 0; i < NCH; i++) begin
      if (r_loc == STU_BASE + 16'(2 * i)) begin
        rd_data     = stu_data[16*i +: 8];
        snap_hit[i] = 1'b1;
      end
      if (r_loc == STU_BASE + 16'(2 * i + 1)) begin
        rd_data = shadow_q[16*i+8 +: 8];
      end
    end
    for (int j = 0; j < NCFG; j++) begin
      if (r_loc == CFG_BASE + 16'(j)) rd_data = cfg_q[8*j +: 8];
    end
  end

  // Write decode: per-register config enables and event write-1-to-clear mask
  always_comb begin
    cfg_we  = '0;
    evt_clr = '0;
    for (int j = 0; j < NCFG; j++) begin
      cfg_we[j] = wr_acc && cfg_unlocked && (w_loc == CFG_BASE + 16'(j));
    end
    if (wr_acc && (w_loc == A_EVT)) evt_clr = fx_data[NCH-1:0];
  end

  // Registered read response; idle cycles return zero data and no valid
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      fx_q  <= 8'h00;
      fx_qv <= 1'b0;
    end else begin
      fx_qv <= rd_acc;
      fx_q  <= rd_acc ? rd_data : 8'h00;
    end
  end

  // Low-byte read freezes the whole status word so the high byte read later is coherent
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rd_acc && snap_hit[i]) shadow_q[16*i +: 16] <= stu_data[16*i +: 16];
      end
    end
  end

  // Config registers with a strobe aligned to the new value appearing on cfg_out
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cfg_q    <= CFG_RST[NCFG*8-1:0];
      cfg_wstb <= '0;
    end else begin
      cfg_wstb <= cfg_we;
      for (int j = 0; j < NCFG; j++) begin
        if (cfg_we[j]) cfg_q[8*j +: 8] <= fx_data;
      end
    end
  end

  // Mask, sticky events (set beats clear) and registered interrupt level
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mask_q <= '0;
      evt_q  <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc && (w_loc == A_MASK)) mask_q <= fx_data[NCH-1:0];
      evt_q <= (evt_q & ~evt_clr) | stu_evt;
      irq   <= |(evt_q & mask_q);
    end
  end

endmodule

// File: tb/tb_fx_regbank.sv
// tb/tb_fx_regbank.sv - directed table-driven bench for fx_regbank (default parameters)

module tb_fx_regbank;

  logic        clk_sys;
  logic        rst;
  logic [5:0]  dev_id;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic        fx_qv;
  logic [63:0] cfg_out;
  logic [7:0]  cfg_wstb;
  logic [31:0] stu_data;
  logic [1:0]  stu_evt;
  logic        irq;

  int checks;
  int failures;

  fx_regbank dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .dev_id   (dev_id),
    .fx_wr    (fx_wr),
    .fx_waddr (fx_waddr),
    .fx_data  (fx_data),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .fx_qv    (fx_qv),
    .cfg_out  (cfg_out),
    .cfg_wstb (cfg_wstb),
    .stu_data (stu_data),
    .stu_evt  (stu_evt),
    .irq      (irq)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  typedef struct {
    logic [5:0]  dev;
    logic        wr;
    logic [21:0] waddr;
    logic [7:0]  wdata;
    logic        rd;
    logic [21:0] raddr;
    logic [31:0] stu;
    logic [1:0]  evt;
    logic [7:0]  exp_q;
    logic        exp_qv;
    logic [63:0] exp_cfg;
    logic [7:0]  exp_wstb;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  localparam logic [63:0] C0 = 64'h8786858483828101;
  localparam logic [63:0] C1 = 64'h878685843C828101;
  localparam logic [63:0] C2 = 64'h878685843C8281EE;
  localparam logic [63:0] C3 = 64'h5A8685843C8281EE;
  localparam logic [31:0] S1 = 32'h1234_5678;
  localparam logic [31:0] S2 = 32'hABCD_5678;
`ifdef FX_REGBANK_LOCK_EN
  localparam logic [7:0] Q_LOCKREG = 8'h01;
`else
  localparam logic [7:0] Q_LOCKREG = 8'h55;
`endif

  function automatic vec_t mk(logic [5:0] dev, logic wr, logic [21:0] waddr, logic [7:0] wdata,
                              logic rd, logic [21:0] raddr, logic [31:0] stu, logic [1:0] evt,
                              logic [7:0] exp_q, logic exp_qv, logic [63:0] exp_cfg,
                              logic [7:0] exp_wstb, logic exp_irq);
    vec_t v;
    v.dev = dev; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
    v.rd = rd; v.raddr = raddr; v.stu = stu; v.evt = evt;
    v.exp_q = exp_q; v.exp_qv = exp_qv; v.exp_cfg = exp_cfg;
    v.exp_wstb = exp_wstb; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dev_id   = v.dev;
    fx_wr    = v.wr;
    fx_waddr = v.waddr;
    fx_data  = v.wdata;
    fx_rd    = v.rd;
    fx_raddr = v.raddr;
    stu_data = v.stu;
    stu_evt  = v.evt;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, "_q"},    64'(fx_q),     64'(v.exp_q));
    chk({tag, "_qv"},   64'(fx_qv),    64'(v.exp_qv));
    chk({tag, "_cfg"},  cfg_out,       v.exp_cfg);
    chk({tag, "_wstb"}, 64'(cfg_wstb), 64'(v.exp_wstb));
    chk({tag, "_irq"},  64'(irq),      64'(v.exp_irq));
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;

    // Reset state
    rst = 1'b1;
    drive(mk(6'h05, 0, 22'h0, 8'h0, 0, 22'h0, S1, 2'b00, 8'h00, 0, C0, 8'h00, 0));
    repeat (2) @(posedge clk_sys);
    #1;
    check_outputs("reset", mk(6'h05, 0, 22'h0, 8'h0, 0, 22'h0, S1, 2'b00, 8'h00, 0, C0, 8'h00, 0));
    rst = 1'b0;

`ifdef FX_REGBANK_LOCK_EN
    // Locked config write ignored, lock readback, unlock, readback
    vq.push_back(mk(6'h05, 1, 22'h050083, 8'h77, 0, 22'h0,      S1, 2'b00, 8'h00, 0, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h05000F, S1, 2'b00, 8'h00, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 1, 22'h05000F, 8'hA5, 0, 22'h0,      S1, 2'b00, 8'h00, 0, C0, 8'h00, 0));
`endif
    // Identity, config and unmapped reads
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050000, S1, 2'b00, 8'h05, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050080, S1, 2'b00, 8'h01, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050081, S1, 2'b00, 8'h81, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050040, S1, 2'b00, 8'h55, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050001, S1, 2'b00, 8'h02, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050002, S1, 2'b00, 8'h08, 1, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h060000, S1, 2'b00, 8'h00, 0, C0, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h05000F, S1, 2'b00, Q_LOCKREG, 1, C0, 8'h00, 0));
    // Config write, strobe, foreign-device write, readback
    vq.push_back(mk(6'h05, 1, 22'h050083, 8'h3C, 0, 22'h0,      S1, 2'b00, 8'h00, 0, C1, 8'h08, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 0, 22'h0,      S1, 2'b00, 8'h00, 0, C1, 8'h00, 0));
    vq.push_back(mk(6'h06, 1, 22'h050083, 8'h99, 0, 22'h0,      S1, 2'b00, 8'h00, 0, C1, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050083, S1, 2'b00, 8'h3C, 1, C1, 8'h00, 0));
    // Coherent status snapshot
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050013, S1, 2'b00, 8'h00, 1, C1, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050012, S1, 2'b00, 8'h34, 1, C1, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050013, S2, 2'b00, 8'h12, 1, C1, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050010, S2, 2'b00, 8'h78, 1, C1, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050011, S2, 2'b00, 8'h56, 1, C1, 8'h00, 0));
    // Same-address read and write returns pre-write value
    vq.push_back(mk(6'h05, 1, 22'h050080, 8'hEE, 1, 22'h050080, S2, 2'b00, 8'h01, 1, C2, 8'h01, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050080, S2, 2'b00, 8'hEE, 1, C2, 8'h00, 0));
    // Mask, event, irq timing, set-beats-clear, clear
    vq.push_back(mk(6'h05, 1, 22'h050009, 8'h02, 0, 22'h0,      S2, 2'b00, 8'h00, 0, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050009, S2, 2'b00, 8'h02, 1, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 0, 22'h0,      S2, 2'b10, 8'h00, 0, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 0, 22'h0,      S2, 2'b00, 8'h00, 0, C2, 8'h00, 1));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050008, S2, 2'b00, 8'h02, 1, C2, 8'h00, 1));
    vq.push_back(mk(6'h05, 1, 22'h050008, 8'h02, 0, 22'h0,      S2, 2'b10, 8'h00, 0, C2, 8'h00, 1));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050008, S2, 2'b00, 8'h02, 1, C2, 8'h00, 1));
    vq.push_back(mk(6'h05, 1, 22'h050008, 8'h02, 0, 22'h0,      S2, 2'b00, 8'h00, 0, C2, 8'h00, 1));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 0, 22'h0,      S2, 2'b00, 8'h00, 0, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 0, 22'h0,      S2, 2'b01, 8'h00, 0, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050008, S2, 2'b00, 8'h01, 1, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 1, 22'h050008, 8'hFF, 1, 22'h050008, S2, 2'b00, 8'h01, 1, C2, 8'h00, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050008, S2, 2'b00, 8'h00, 1, C2, 8'h00, 0));
    // Last config register
    vq.push_back(mk(6'h05, 1, 22'h050087, 8'h5A, 0, 22'h0,      S2, 2'b00, 8'h00, 0, C3, 8'h80, 0));
    vq.push_back(mk(6'h05, 0, 22'h0,      8'h00, 1, 22'h050087, S2, 2'b00, 8'h5A, 1, C3, 8'h00, 0));

    foreach (vq[k]) begin
      drive(vq[k]);
      @(posedge clk_sys);
      #1;
      check_outputs($sformatf("vec%0d", k), vq[k]);
    end

    // Reset arriving together with a read: response dropped, config back to reset values
    v = mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050081, S2, 2'b00, 8'h81, 1, C3, 8'h00, 0);
    drive(v);
    @(posedge clk_sys);
    #1;
    check_outputs("pre_rst_read", v);
    v = mk(6'h05, 1, 22'h050082, 8'h11, 1, 22'h050080, S2, 2'b11, 8'h00, 0, C0, 8'h00, 0);
    drive(v);
    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    check_outputs("mid_rst", v);
    rst = 1'b0;
    v = mk(6'h05, 0, 22'h0, 8'h00, 1, 22'h050008, S2, 2'b00, 8'h00, 1, C0, 8'h00, 0);
    drive(v);
    @(posedge clk_sys);
    #1;
    check_outputs("post_rst_evt", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fx_regbank.md
Name: fx_regbank

Overview:
- Parametrised fx-bus register bank, next generation of the per-device register file used in each acquisition top.
- Decodes fx-bus reads and writes for one device and exposes NCFG 8-bit config registers and NCH 16-bit status channels.
- Adds write strobes, coherent 16-bit status reads, sticky per-channel events with an interrupt, and a read-valid flag.

Parameters:
- NCH, 2, number of 16-bit status channels (1..8).
- NCFG, 8, number of 8-bit config registers (1..32).
- STU_BASE, 16'h0010, local address of channel 0 status low byte.
- CFG_BASE, 16'h0080, local address of config register 0.
- CFG_RST, 256'h...8786858483828101, packed reset values; byte j is the reset value of cfg j; only the low NCFG bytes are used.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dev_id  in  6  device select, compared with address bits [21:16]
- fx_wr  in  1  write strobe
- fx_waddr  in  22  write address
- fx_data  in  8  write data
- fx_rd  in  1  read strobe
- fx_raddr  in  22  read address
- fx_q  out  8  read data
- fx_qv  out  1  read data valid
- cfg_out  out  NCFG*8  config registers; byte j is cfg j
- cfg_wstb  out  NCFG  one-cycle pulse per config register written
- stu_data  in  NCH*16  status inputs; word i is channel i
- stu_evt  in  NCH  per-channel event pulses
- irq  out  1  interrupt, level

Behaviour:
- One clock, clk_sys. Reset is synchronous and active-high (rst); all state changes on the rising edge of clk_sys.
- Device select:
  - Write accepted = fx_wr & (fx_waddr[21:16] == dev_id).
  - Read accepted = fx_rd & (fx_raddr[21:16] == dev_id).
  - All decode below uses local address bits [15:0].
- Reset values:
  - cfg j = CFG_RST byte j.
  - fx_q = 0, fx_qv = 0, cfg_wstb = 0, irq = 0.
  - Event register = 0, mask = 0, all snapshot shadows = 0, lock = locked.
- Read path:
  - Latency is exactly 1 cycle: fx_q and fx_qv are registered.
  - A cycle with no accepted read gives fx_q = 0 and fx_qv = 0.
  - Reads have no side effects except the snapshot capture described below.
- Read map:
  - 0x0000: {2'b0, dev_id}
  - 0x0001: NCH
  - 0x0002: NCFG
  - 0x0008: event register, zero-extended to 8 bits
  - 0x0009: irq mask
  - STU_BASE+2i: low byte of stu_data word i. Same edge captures the full 16-bit word into shadow i.
  - STU_BASE+2i+1: shadow i [15:8]. If no low-byte read has occurred since reset, returns the reset shadow value 0.
  - CFG_BASE+j: cfg j
  - Any unmapped address: 8'h55.
- Write map:
  - CFG_BASE+j: cfg j <= fx_data; cfg_wstb[j] = 1 in the same cycle the new value appears on cfg_out.
  - 0x0009: mask <= fx_data[NCH-1:0].
  - 0x0008: write-1-to-clear on event bits.
  - All other writes are ignored.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Events:
  - evt[i] sets on stu_evt[i] = 1 and is sticky.
  - If set and clear hit the same bit in the same cycle, set wins.
- irq is registered: irq <= |(evt & mask). It rises 1 cycle after the event bit sets (2 edges after the stu_evt pulse).
- Reset asserted mid-transaction: outputs return to reset values on that edge; the pending read response is dropped (fx_qv = 0).

Optional Feature:
- Macro: FX_REGBANK_LOCK_EN.
- With the macro defined:
  - Local address 0x000F is the lock register. Writing 8'hA5 unlocks; writing any other value locks.
  - Reading 0x000F returns 8'h01 when unlocked and 8'h00 when locked.
  - Config writes while locked are ignored and produce no cfg_wstb.
  - Mask and event-clear writes are never locked.
- Without the macro: config registers are always writable, and 0x000F is an unmapped address (reads 8'h55, writes ignored).

Test Plan:
- After reset with dev_id = 6'h05 and defaults, read 0x050000, 0x050080, 0x050081, 0x050040 → fx_q = 8'h05, 8'h01, 8'h81, 8'h55 on the cycle after each read, each with fx_qv = 1.
- Write 0x3C to 0x050083 → cfg 3 = 8'h3C and cfg_wstb[3] pulses for one cycle. Repeat the write with dev_id = 6'h06 → no change and no strobe.
- stu_data ch1 = 16'h1234; read 0x050012; change the input to 16'hABCD; read 0x050013 → fx_q = 8'h34, then 8'h12 (coherent snapshot).
- Write mask = 8'h02; pulse stu_evt[1] → irq = 1 after 2 edges. Write 0x02 to 0x050008 in the same cycle as a new stu_evt[1] pulse → evt stays 1. Repeat the clear with no event → irq = 0 one cycle later.
- Assert rst during a pending read → the next cycle has fx_qv = 0 and fx_q = 0, and cfg 0 = 8'h01.
- With FX_REGBANK_LOCK_EN defined: a cfg write while locked is ignored; write 8'hA5 to 0x05000F, then a cfg write succeeds and reading 0x05000F returns 8'h01.
